uvmt_cv32e40x_sl_trigger_match_tracker: RTL and testbench

Parametrised, clocked successor to the combinational trigger-match support logic in `tb/uvmt/support_logic`. It evaluates execute, exception and load/store trigger matches for every retired instruction. Memory accesses are consumed as a serial stream while the instruction is in flight and buffered per instruction in a FIFO until it retires. It also keeps per-trigger saturating hit counters and sticky error flags for the assertion and coverage layers.

---
 rtl/uvmt_cv32e40x_sl_trigger_match_tracker_if.sv | 54 +++++
 rtl/uvmt_cv32e40x_sl_trigger_match_tracker.sv | 214 +++++++++++++++++++++
 tb/tb_uvmt_cv32e40x_sl_trigger_match_tracker.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uvmt_cv32e40x_sl_trigger_match_tracker_if.sv
// Connection bundle for the trigger-match tracker: trigger CSRs, memory access stream,
// retire information, and the registered match results, counters and error flags.
interface uvmt_cv32e40x_sl_trigger_match_tracker_if #(
    parameter int NUM_TRIGGERS   = 4,
    parameter int MAX_MEM_ACCESS = 13,
    parameter int CNT_W          = 16
);
    localparam int IDX_W = (MAX_MEM_ACCESS > 1) ? $clog2(MAX_MEM_ACCESS) : 1;

    logic [NUM_TRIGGERS-1:0][31:0]      tdata1_array;
    logic [NUM_TRIGGERS-1:0][31:0]      tdata2_array;
    logic                               mem_valid;
    logic [31:0]                        mem_addr;
    logic                               mem_we;
    logic                               mem_last;
    logic                               retire_valid;
    logic                               retire_has_mem;
    logic [31:0]                        retire_pc;
    logic                               retire_dbg_mode;
    logic                               retire_mmode;
    logic                               retire_umode;
    logic                               retire_exception;
    logic [4:0]                         retire_exception_cause;
    logic                               retire_clicptr;

    logic                               match_valid;
    logic [NUM_TRIGGERS-1:0]            trigger_match_execute;
    logic [NUM_TRIGGERS-1:0]            trigger_match_exception;
    logic [NUM_TRIGGERS-1:0]            trigger_match_mem;
    logic [NUM_TRIGGERS-1:0]            is_trigger_match;
    logic [IDX_W-1:0]                   mem_access_idx;
    logic [NUM_TRIGGERS-1:0][CNT_W-1:0] hit_count;
    logic                               fifo_overflow;
    logic                               fifo_underflow;
    logic                               access_overflow;

    modport master (
        output tdata1_array, tdata2_array, mem_valid, mem_addr, mem_we, mem_last,
               retire_valid, retire_has_mem, retire_pc, retire_dbg_mode, retire_mmode,
               retire_umode, retire_exception, retire_exception_cause, retire_clicptr,
        input  match_valid, trigger_match_execute, trigger_match_exception,
               trigger_match_mem, is_trigger_match, mem_access_idx, hit_count,
               fifo_overflow, fifo_underflow, access_overflow
    );

    modport slave (
        input  tdata1_array, tdata2_array, mem_valid, mem_addr, mem_we, mem_last,
               retire_valid, retire_has_mem, retire_pc, retire_dbg_mode, retire_mmode,
               retire_umode, retire_exception, retire_exception_cause, retire_clicptr,
        output match_valid, trigger_match_execute, trigger_match_exception,
               trigger_match_mem, is_trigger_match, mem_access_idx, hit_count,
               fifo_overflow, fifo_underflow, access_overflow
    );
endinterface

// File: rtl/uvmt_cv32e40x_sl_trigger_match_tracker.sv
// Clocked trigger-match tracker: per-access load/store evaluation grouped per instruction,
// FIFO-buffered until retire, then merged with execute/exception matches and counted.
module uvmt_cv32e40x_sl_trigger_match_tracker #(
    parameter int NUM_TRIGGERS   = 4,
    parameter int MAX_MEM_ACCESS = 13,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_W          = 16
) (
    input logic clk_i,
    input logic rst_i,
    uvmt_cv32e40x_sl_trigger_match_tracker_if.slave bus
);
    localparam int NT     = NUM_TRIGGERS;
    localparam int IDX_W  = (MAX_MEM_ACCESS > 1) ? $clog2(MAX_MEM_ACCESS) : 1;
    localparam int ACNT_W = $clog2(MAX_MEM_ACCESS + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    function automatic logic f_is_m26(input logic [31:0] t1);
        return (t1[31:28] == 4'd2) || (t1[31:28] == 4'd6);
    endfunction

    function automatic logic f_is_etrig(input logic [31:0] t1);
        return t1[31:28] == 4'd5;
    endfunction

    function automatic logic f_cmp(input logic [3:0] mtype, input logic [31:0] val,
                                   input logic [31:0] tval);
        case (mtype)
            4'd0:    return val == tval;
            4'd2:    return val >= tval;
            4'd3:    return val < tval;
            default: return 1'b0;
        endcase
    endfunction

    // The M/U bit positions differ between address/data and exception triggers.
    function automatic logic f_mode_ok(input logic [31:0] t1, input logic mm, input logic um);
        if (f_is_m26(t1))   return (mm & t1[6]) | (um & t1[3]);
        if (f_is_etrig(t1)) return (mm & t1[9]) | (um & t1[6]);
        return 1'b0;
    endfunction

    logic [NT-1:0]            r_acc_vec;
    logic [IDX_W-1:0]         r_acc_idx;
    logic [ACNT_W-1:0]        r_acc_cnt;
    logic [NT-1:0]            r_fifo_vec [FIFO_DEPTH];
    logic [IDX_W-1:0]         r_fifo_idx [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [FCNT_W-1:0]        r_fifo_cnt;
    logic                     r_match_valid;
    logic [NT-1:0]            r_exec;
    logic [NT-1:0]            r_exc;
    logic [NT-1:0]            r_mem;
    logic [NT-1:0]            r_match;
    logic [IDX_W-1:0]         r_idx;
    logic [NT-1:0][CNT_W-1:0] r_hit_count;
    logic                     r_fifo_ovf;
    logic                     r_fifo_unf;
    logic                     r_acc_ovf;

    logic                     w_acc_room;
    logic                     w_eval;
    logic [NT-1:0]            w_access_hit;
    logic [NT-1:0]            w_grp_vec;
    logic [IDX_W-1:0]         w_grp_idx;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic                     w_bypass;
    logic                     w_fifo_wr;
    logic                     w_fifo_rd;
    logic [NT-1:0]            w_pop_vec;
    logic [IDX_W-1:0]         w_pop_idx;
    logic [NT-1:0]            w_mode_ok;
    logic [NT-1:0]            w_exec;
    logic [NT-1:0]            w_exc;
    logic [NT-1:0]            w_mem;
    logic [NT-1:0]            w_match;

    // Group result including the access presented this cycle; first hit wins.
    always_comb begin
        w_acc_room   = r_acc_cnt < ACNT_W'(MAX_MEM_ACCESS);
        w_eval       = bus.mem_valid && w_acc_room;
        w_access_hit = '0;
        for (int t = 0; t < NT; t++) begin
            w_access_hit[t] = w_eval && f_is_m26(bus.tdata1_array[t])
                && (bus.mem_we ? bus.tdata1_array[t][1] : bus.tdata1_array[t][0])
                && f_cmp(bus.tdata1_array[t][10:7], bus.mem_addr, bus.tdata2_array[t]);
        end
        w_grp_vec = r_acc_vec;
        w_grp_idx = r_acc_idx;
        if ((r_acc_vec == '0) && (w_access_hit != '0)) begin
            w_grp_vec = w_access_hit;
            w_grp_idx = r_acc_cnt[IDX_W-1:0];
        end
    end

    assign w_push       = bus.mem_valid && bus.mem_last;
    assign w_pop        = bus.retire_valid && bus.retire_has_mem;
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_fifo_full  = (r_fifo_cnt == FCNT_W'(FIFO_DEPTH));
    assign w_bypass     = w_push && w_pop && w_fifo_empty;
    assign w_fifo_wr    = w_push && !w_bypass && (!w_fifo_full || w_pop);
    assign w_fifo_rd    = w_pop && !w_fifo_empty;

    always_comb begin
        w_pop_vec = '0;
        w_pop_idx = '0;
        if (w_bypass) begin
            w_pop_vec = w_grp_vec;
            w_pop_idx = w_grp_idx;
        end else if (w_fifo_rd) begin
            w_pop_vec = r_fifo_vec[r_rd_ptr];
            w_pop_idx = r_fifo_idx[r_rd_ptr];
        end
    end

    always_comb begin
        w_mode_ok = '0;
        w_exec    = '0;
        w_exc     = '0;
        for (int t = 0; t < NT; t++) begin
            w_mode_ok[t] = f_mode_ok(bus.tdata1_array[t], bus.retire_mmode, bus.retire_umode);
            w_exec[t] = bus.retire_valid && !bus.retire_dbg_mode && !bus.retire_clicptr
                && f_is_m26(bus.tdata1_array[t]) && w_mode_ok[t] && bus.tdata1_array[t][2]
                && f_cmp(bus.tdata1_array[t][10:7], bus.retire_pc, bus.tdata2_array[t]);
            w_exc[t] = bus.retire_valid && !bus.retire_dbg_mode
                && f_is_etrig(bus.tdata1_array[t]) && w_mode_ok[t] && bus.retire_exception
                && bus.tdata2_array[t][bus.retire_exception_cause];
        end
        if (w_exec != '0) w_exc = '0;
        w_mem   = ((w_exec != '0) || (w_exc != '0)) ? '0 : (w_pop_vec & w_mode_ok);
        w_match = w_exec | w_exc | w_mem;
    end

    // Storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (w_fifo_wr) begin
            r_fifo_vec[r_wr_ptr] <= w_grp_vec;
            r_fifo_idx[r_wr_ptr] <= w_grp_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc_vec     <= '0;
            r_acc_idx     <= '0;
            r_acc_cnt     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fifo_cnt    <= '0;
            r_match_valid <= 1'b0;
            r_exec        <= '0;
            r_exc         <= '0;
            r_mem         <= '0;
            r_match       <= '0;
            r_idx         <= '0;
            r_hit_count   <= '0;
            r_fifo_ovf    <= 1'b0;
            r_fifo_unf    <= 1'b0;
            r_acc_ovf     <= 1'b0;
        end else begin
            r_match_valid <= bus.retire_valid;
            r_exec        <= w_exec;
            r_exc         <= w_exc;
            r_mem         <= w_mem;
            r_match       <= w_match;
            r_idx         <= w_pop_idx;

            // Counters advance together with the match vectors they count.
            for (int t = 0; t < NT; t++) begin
                if (w_match[t] && (r_hit_count[t] != '1))
                    r_hit_count[t] <= r_hit_count[t] + CNT_W'(1);
            end

            if (w_push) begin
                r_acc_vec <= '0;
                r_acc_idx <= '0;
                r_acc_cnt <= '0;
            end else if (w_eval) begin
                r_acc_vec <= w_grp_vec;
                r_acc_idx <= w_grp_idx;
                r_acc_cnt <= r_acc_cnt + ACNT_W'(1);
            end

            if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_fifo_wr, w_fifo_rd})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + FCNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - FCNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase

            if (bus.mem_valid && !w_acc_room)           r_acc_ovf  <= 1'b1;
            if (w_push && w_fifo_full && !w_pop)        r_fifo_ovf <= 1'b1;
            if (w_pop && w_fifo_empty && !w_push)       r_fifo_unf <= 1'b1;
        end
    end

    assign bus.match_valid             = r_match_valid;
    assign bus.trigger_match_execute   = r_exec;
    assign bus.trigger_match_exception = r_exc;
    assign bus.trigger_match_mem       = r_mem;
    assign bus.is_trigger_match        = r_match;
    assign bus.mem_access_idx          = r_idx;
    assign bus.hit_count               = r_hit_count;
    assign bus.fifo_overflow           = r_fifo_ovf;
    assign bus.fifo_underflow          = r_fifo_unf;
    assign bus.access_overflow         = r_acc_ovf;

endmodule

// File: tb/tb_uvmt_cv32e40x_sl_trigger_match_tracker.sv
// Bench for the trigger-match tracker: directed scenarios plus randomized traffic
// checked against a queue-based reference model of instruction groups.
module tb_uvmt_cv32e40x_sl_trigger_match_tracker;
    localparam int NT    = 4;
    localparam int MAXA  = 13;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int IDX_W = $clog2(MAXA);

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    uvmt_cv32e40x_sl_trigger_match_tracker_if #(
        .NUM_TRIGGERS(NT), .MAX_MEM_ACCESS(MAXA), .CNT_W(CW)
    ) bus ();

    uvmt_cv32e40x_sl_trigger_match_tracker #(
        .NUM_TRIGGERS(NT), .MAX_MEM_ACCESS(MAXA), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [NT-1:0] q_vec[$];
    int            q_idx[$];
    int            acc_n;
    int            acc_first;
    logic [NT-1:0] acc_vec;
    bit            m_fovf, m_funf, m_aovf;
    int            m_cnt[NT];
    logic          exp_valid;
    logic [NT-1:0] exp_exec, exp_exc, exp_mem, exp_match;
    int            exp_idx;

    function automatic bit cmp_ok(input logic [3:0] m, input logic [31:0] v, input logic [31:0] d);
        if (m == 4'd0) return v == d;
        if (m == 4'd2) return v >= d;
        if (m == 4'd3) return v < d;
        return 1'b0;
    endfunction

    function automatic bit is_addr_trig(input logic [31:0] t1);
        return (t1[31:28] == 4'd2) || (t1[31:28] == 4'd6);
    endfunction

    function automatic bit mode_ok(input logic [31:0] t1, input bit mm, input bit um);
        if (is_addr_trig(t1))    return (mm && t1[6]) || (um && t1[3]);
        if (t1[31:28] == 4'd5)   return (mm && t1[9]) || (um && t1[6]);
        return 1'b0;
    endfunction

    task automatic idle();
        bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_we = 0; bus.mem_last = 0;
        bus.retire_valid = 0; bus.retire_has_mem = 0; bus.retire_pc = 0;
        bus.retire_dbg_mode = 0; bus.retire_mmode = 1; bus.retire_umode = 0;
        bus.retire_exception = 0; bus.retire_exception_cause = 0; bus.retire_clicptr = 0;
    endtask

    task automatic clear_trig();
        for (int t = 0; t < NT; t++) begin
            bus.tdata1_array[t] = 32'h0;
            bus.tdata2_array[t] = 32'h0;
        end
    endtask

    // Advance one clock; the model predicts what the outputs show afterwards.
    task automatic tick();
        logic [NT-1:0] hv, pv, gvec;
        int            pidx, gidx;
        bit            gdone;
        logic [31:0]   t1, t2;
        exp_valid = 0; exp_exec = 0; exp_exc = 0; exp_mem = 0; exp_match = 0; exp_idx = 0;
        if (rst_i) begin
            q_vec.delete(); q_idx.delete();
            acc_n = 0; acc_first = 0; acc_vec = 0;
            m_fovf = 0; m_funf = 0; m_aovf = 0;
            for (int t = 0; t < NT; t++) m_cnt[t] = 0;
        end else begin
            gdone = 0; gvec = 0; gidx = 0; pv = 0; pidx = 0;
            if (bus.mem_valid) begin
                if (acc_n < MAXA) begin
                    hv = 0;
                    for (int t = 0; t < NT; t++) begin
                        t1 = bus.tdata1_array[t]; t2 = bus.tdata2_array[t];
                        if (is_addr_trig(t1) && (bus.mem_we ? t1[1] : t1[0]) &&
                            cmp_ok(t1[10:7], bus.mem_addr, t2)) hv[t] = 1;
                    end
                    if (acc_vec == 0 && hv != 0) begin acc_vec = hv; acc_first = acc_n; end
                    acc_n++;
                end else m_aovf = 1;
                if (bus.mem_last) begin
                    gdone = 1; gvec = acc_vec; gidx = acc_first;
                    acc_n = 0; acc_vec = 0; acc_first = 0;
                end
            end
            if (bus.retire_valid && bus.retire_has_mem) begin
                if (q_vec.size() > 0) begin pv = q_vec.pop_front(); pidx = q_idx.pop_front(); end
                else if (gdone) begin pv = gvec; pidx = gidx; gdone = 0; end
                else m_funf = 1;
            end
            if (gdone) begin
                if (q_vec.size() < DEPTH) begin q_vec.push_back(gvec); q_idx.push_back(gidx); end
                else m_fovf = 1;
            end
            if (bus.retire_valid) begin
                exp_valid = 1;
                for (int t = 0; t < NT; t++) begin
                    t1 = bus.tdata1_array[t]; t2 = bus.tdata2_array[t];
                    if (!bus.retire_dbg_mode && !bus.retire_clicptr && is_addr_trig(t1) &&
                        mode_ok(t1, bus.retire_mmode, bus.retire_umode) && t1[2] &&
                        cmp_ok(t1[10:7], bus.retire_pc, t2)) exp_exec[t] = 1;
                    if (!bus.retire_dbg_mode && t1[31:28] == 4'd5 &&
                        mode_ok(t1, bus.retire_mmode, bus.retire_umode) &&
                        bus.retire_exception && t2[bus.retire_exception_cause]) exp_exc[t] = 1;
                end
                if (exp_exec != 0) exp_exc = 0;
                if (exp_exec == 0 && exp_exc == 0)
                    for (int t = 0; t < NT; t++)
                        exp_mem[t] = pv[t] && mode_ok(bus.tdata1_array[t], bus.retire_mmode,
                                                      bus.retire_umode);
                exp_match = exp_exec | exp_exc | exp_mem;
                exp_idx = pidx;
                for (int t = 0; t < NT; t++)
                    if (exp_match[t] && m_cnt[t] < (1 << CW) - 1) m_cnt[t]++;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1; idle(); tick(); rst_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1; idle(); clear_trig(); tick(); tick(); rst_i = 0;
        n_tests++;
        if (bus.match_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus.match_valid);
        end
        n_tests++;
        if ({bus.trigger_match_execute, bus.trigger_match_exception, bus.trigger_match_mem,
             bus.is_trigger_match} !== '0) begin
            n_fail++; $display("FAIL reset_vectors: got %0h %0h %0h %0h expected 0",
                bus.trigger_match_execute, bus.trigger_match_exception,
                bus.trigger_match_mem, bus.is_trigger_match);
        end
        n_tests++;
        if (bus.mem_access_idx !== '0 || bus.hit_count !== '0) begin
            n_fail++; $display("FAIL reset_idx_count: got idx %0d cnt %0h expected 0",
                bus.mem_access_idx, bus.hit_count);
        end
        n_tests++;
        if ({bus.fifo_overflow, bus.fifo_underflow, bus.access_overflow} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000",
                {bus.fifo_overflow, bus.fifo_underflow, bus.access_overflow});
        end
    endtask

    task automatic test_execute_equal();
        clear_trig();
        bus.tdata1_array[0] = 32'h2800_0044; bus.tdata2_array[0] = 32'h100;
        bus.retire_valid = 1; bus.retire_pc = 32'h100;
        tick(); idle();
        n_tests++;
        if (bus.match_valid !== 1'b1 || bus.trigger_match_execute !== 4'h1 ||
            bus.is_trigger_match !== 4'h1) begin
            n_fail++; $display("FAIL exec_equal: got valid %0b exec %0h match %0h expected 1 1 1",
                bus.match_valid, bus.trigger_match_execute, bus.is_trigger_match);
        end
        n_tests++;
        if (bus.hit_count[0] !== 2'd1) begin
            n_fail++; $display("FAIL exec_hit_count: got %0d expected 1", bus.hit_count[0]);
        end
        tick();
        n_tests++;
        if (bus.match_valid !== 1'b0 || bus.trigger_match_execute !== 4'h0) begin
            n_fail++; $display("FAIL exec_pulse_width: got valid %0b exec %0h expected 0 0",
                bus.match_valid, bus.trigger_match_execute);
        end
    endtask

    task automatic test_store_group();
        logic [31:0] addrs [3];
        addrs = '{32'h1FFC, 32'h2000, 32'h2000};
        clear_trig();
        bus.tdata1_array[1] = 32'h2800_0042; bus.tdata2_array[1] = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            bus.mem_valid = 1; bus.mem_we = 1; bus.mem_addr = addrs[i]; bus.mem_last = (i == 2);
            tick();
        end
        idle();
        bus.retire_valid = 1; bus.retire_has_mem = 1; bus.retire_pc = 32'h8000;
        tick(); idle();
        n_tests++;
        if (bus.match_valid !== 1'b1 || bus.trigger_match_mem !== 4'h2 ||
            bus.mem_access_idx !== 4'd1 || bus.trigger_match_execute !== 4'h0) begin
            n_fail++; $display("FAIL store_group: got valid %0b mem %0h idx %0d exec %0h expected 1 2 1 0",
                bus.match_valid, bus.trigger_match_mem, bus.mem_access_idx, bus.trigger_match_execute);
        end
    endtask

    task automatic test_priority();
        clear_trig();
        bus.tdata1_array[0] = 32'h2800_0044; bus.tdata2_array[0] = 32'h100;
        bus.tdata1_array[1] = 32'h2800_0041; bus.tdata2_array[1] = 32'h3000;
        bus.tdata1_array[2] = 32'h5000_0200; bus.tdata2_array[2] = 32'h4;
        bus.mem_valid = 1; bus.mem_we = 0; bus.mem_addr = 32'h3000; bus.mem_last = 1;
        tick(); idle();
        bus.retire_valid = 1; bus.retire_has_mem = 1; bus.retire_pc = 32'h100;
        tick(); idle();
        n_tests++;
        if (bus.trigger_match_execute !== 4'h1 || bus.trigger_match_mem !== 4'h0 ||
            bus.is_trigger_match !== 4'h1) begin
            n_fail++; $display("FAIL exec_over_mem: got exec %0h mem %0h match %0h expected 1 0 1",
                bus.trigger_match_execute, bus.trigger_match_mem, bus.is_trigger_match);
        end
        bus.retire_valid = 1; bus.retire_pc = 32'h200;
        bus.retire_exception = 1; bus.retire_exception_cause = 5'd2;
        tick(); idle();
        n_tests++;
        if (bus.trigger_match_exception !== 4'h4 || bus.trigger_match_execute !== 4'h0) begin
            n_fail++; $display("FAIL exception_match: got exc %0h exec %0h expected 4 0",
                bus.trigger_match_exception, bus.trigger_match_execute);
        end
        bus.retire_valid = 1; bus.retire_pc = 32'h100;
        bus.retire_exception = 1; bus.retire_exception_cause = 5'd2;
        tick(); idle();
        n_tests++;
        if (bus.trigger_match_exception !== 4'h0 || bus.trigger_match_execute !== 4'h1) begin
            n_fail++; $display("FAIL exec_over_exception: got exc %0h exec %0h expected 0 1",
                bus.trigger_match_exception, bus.trigger_match_execute);
        end
    endtask

    task automatic test_fifo_limits();
        logic [NT-1:0] want;
        do_reset(); clear_trig();
        bus.tdata1_array[1] = 32'h2800_0041; bus.tdata2_array[1] = 32'h3000;
        bus.tdata1_array[3] = 32'h2800_0141; bus.tdata2_array[3] = 32'h3000;
        for (int i = 0; i <= DEPTH; i++) begin
            bus.mem_valid = 1; bus.mem_we = 0; bus.mem_last = 1;
            bus.mem_addr = (i % 2 == 1) ? 32'h3000 : 32'h3004;
            tick(); idle();
            n_tests++;
            if (bus.fifo_overflow !== (i == DEPTH)) begin
                n_fail++; $display("FAIL fifo_overflow_%0d: got %0b expected %0b",
                    i, bus.fifo_overflow, i == DEPTH);
            end
        end
        for (int i = 0; i <= DEPTH; i++) begin
            bus.retire_valid = 1; bus.retire_has_mem = 1; bus.retire_pc = 32'h9000;
            tick(); idle();
            want = (i == DEPTH) ? 4'h0 : ((i % 2 == 1) ? 4'hA : 4'h8);
            n_tests++;
            if (bus.trigger_match_mem !== want || bus.fifo_underflow !== (i == DEPTH)) begin
                n_fail++; $display("FAIL fifo_pop_%0d: got mem %0h underflow %0b expected %0h %0b",
                    i, bus.trigger_match_mem, bus.fifo_underflow, want, i == DEPTH);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(); clear_trig();
        bus.tdata1_array[0] = 32'h2800_0044; bus.tdata2_array[0] = 32'h100;
        for (int i = 0; i < 3; i++) begin
            bus.retire_valid = 1; bus.retire_pc = 32'h100;
            tick();
            n_tests++;
            if (bus.match_valid !== 1'b1 || bus.trigger_match_execute !== 4'h1) begin
                n_fail++; $display("FAIL back_to_back_%0d: got valid %0b exec %0h expected 1 1",
                    i, bus.match_valid, bus.trigger_match_execute);
            end
        end
        idle();
    endtask

    task automatic test_bypass();
        do_reset(); clear_trig();
        bus.tdata1_array[2] = 32'h2800_0142; bus.tdata2_array[2] = 32'h1000;
        bus.mem_valid = 1; bus.mem_we = 1; bus.mem_addr = 32'h0800;
        tick();
        bus.mem_addr = 32'h1800; bus.mem_last = 1;
        bus.retire_valid = 1; bus.retire_has_mem = 1; bus.retire_pc = 32'h7000;
        tick(); idle();
        n_tests++;
        if (bus.trigger_match_mem !== 4'h4 || bus.mem_access_idx !== 4'd1 ||
            bus.fifo_underflow !== 1'b0) begin
            n_fail++; $display("FAIL bypass: got mem %0h idx %0d underflow %0b expected 4 1 0",
                bus.trigger_match_mem, bus.mem_access_idx, bus.fifo_underflow);
        end
    endtask

    task automatic test_saturation();
        int want;
        do_reset(); clear_trig();
        bus.tdata1_array[0] = 32'h2800_0044; bus.tdata2_array[0] = 32'h100;
        for (int i = 1; i <= 4; i++) begin
            bus.retire_valid = 1; bus.retire_pc = 32'h100;
            tick(); idle();
            want = (i > 3) ? 3 : i;
            n_tests++;
            if (bus.hit_count[0] !== 2'(want)) begin
                n_fail++; $display("FAIL saturation_%0d: got %0d expected %0d",
                    i, bus.hit_count[0], want);
            end
        end
    endtask

    task automatic test_reset_mid_group();
        clear_trig();
        bus.tdata1_array[0] = 32'h2800_0044; bus.tdata2_array[0] = 32'h100;
        bus.tdata1_array[1] = 32'h2800_0041; bus.tdata2_array[1] = 32'h3000;
        bus.mem_valid = 1; bus.mem_addr = 32'h1; tick();
        bus.mem_addr = 32'h3000; tick();
        rst_i = 1; bus.retire_valid = 1; bus.retire_pc = 32'h100;
        tick(); rst_i = 0; idle();
        n_tests++;
        if (bus.match_valid !== 1'b0 || bus.is_trigger_match !== '0 ||
            bus.hit_count !== '0 || bus.mem_access_idx !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got valid %0b match %0h cnt %0h idx %0d expected 0",
                bus.match_valid, bus.is_trigger_match, bus.hit_count, bus.mem_access_idx);
        end
        bus.mem_valid = 1; bus.mem_addr = 32'h3000; bus.mem_last = 1;
        bus.retire_valid = 1; bus.retire_has_mem = 1; bus.retire_pc = 32'h4000;
        tick(); idle();
        n_tests++;
        if (bus.trigger_match_mem !== 4'h2 || bus.mem_access_idx !== 4'd0) begin
            n_fail++; $display("FAIL reset_mid_next_group: got mem %0h idx %0d expected 2 0",
                bus.trigger_match_mem, bus.mem_access_idx);
        end
    endtask

    task automatic test_access_overflow();
        do_reset(); clear_trig();
        bus.tdata1_array[1] = 32'h2800_0041; bus.tdata2_array[1] = 32'h3000;
        for (int i = 0; i < MAXA; i++) begin
            bus.mem_valid = 1; bus.mem_addr = 32'h0; tick();
        end
        n_tests++;
        if (bus.access_overflow !== 1'b0) begin
            n_fail++; $display("FAIL access_at_limit: got %0b expected 0", bus.access_overflow);
        end
        bus.mem_addr = 32'h3000; bus.mem_last = 1;
        tick(); idle();
        bus.retire_valid = 1; bus.retire_has_mem = 1; bus.retire_pc = 32'h5000;
        tick(); idle();
        n_tests++;
        if (bus.access_overflow !== 1'b1 || bus.trigger_match_mem !== 4'h0) begin
            n_fail++; $display("FAIL access_overflow: got flag %0b mem %0h expected 1 0",
                bus.access_overflow, bus.trigger_match_mem);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [5];
        logic [3:0]  types [6];
        logic [3:0]  typ;
        logic [31:0] low;
        logic [NT-1:0][CW-1:0] ecnt;
        pool  = '{32'hFC, 32'h100, 32'h104, 32'h200, 32'h300};
        types = '{4'd2, 4'd6, 4'd5, 4'd0, 4'd2, 4'd6};
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c % 25 == 0) begin
                for (int t = 0; t < NT; t++) begin
                    typ = types[$urandom_range(0, 5)];
                    low = $urandom & 32'h0000_07CF;
                    bus.tdata1_array[t] = {typ, low[27:0]};
                    bus.tdata2_array[t] = (typ == 4'd5) ? $urandom : pool[$urandom_range(0, 4)];
                end
            end
            bus.mem_valid = 1'($urandom_range(0, 1));
            bus.mem_addr  = pool[$urandom_range(0, 4)];
            bus.mem_we    = 1'($urandom_range(0, 1));
            bus.mem_last  = ($urandom_range(0, 2) == 0);
            bus.retire_valid   = ($urandom_range(0, 2) == 0);
            bus.retire_has_mem = 1'($urandom_range(0, 1));
            bus.retire_pc      = pool[$urandom_range(0, 4)];
            bus.retire_dbg_mode = ($urandom_range(0, 7) == 0);
            bus.retire_mmode   = 1'($urandom_range(0, 1));
            bus.retire_umode   = !bus.retire_mmode;
            bus.retire_exception = 1'($urandom_range(0, 1));
            bus.retire_exception_cause = 5'($urandom_range(0, 31));
            bus.retire_clicptr = ($urandom_range(0, 7) == 0);
            tick();
            n_tests++;
            if (bus.match_valid !== exp_valid || bus.trigger_match_execute !== exp_exec ||
                bus.trigger_match_exception !== exp_exc || bus.trigger_match_mem !== exp_mem ||
                bus.is_trigger_match !== exp_match || bus.mem_access_idx !== IDX_W'(exp_idx)) begin
                n_fail++; $display("FAIL random_vec_%0d: got v%0b x%0h e%0h m%0h a%0h i%0d expected v%0b x%0h e%0h m%0h a%0h i%0d",
                    c, bus.match_valid, bus.trigger_match_execute, bus.trigger_match_exception,
                    bus.trigger_match_mem, bus.is_trigger_match, bus.mem_access_idx,
                    exp_valid, exp_exec, exp_exc, exp_mem, exp_match, exp_idx);
            end
            for (int t = 0; t < NT; t++) ecnt[t] = CW'(m_cnt[t]);
            n_tests++;
            if (bus.hit_count !== ecnt) begin
                n_fail++; $display("FAIL random_count_%0d: got %0h expected %0h", c, bus.hit_count, ecnt);
            end
            n_tests++;
            if ({bus.fifo_overflow, bus.fifo_underflow, bus.access_overflow} !==
                {m_fovf, m_funf, m_aovf}) begin
                n_fail++; $display("FAIL random_flags_%0d: got %b expected %b", c,
                    {bus.fifo_overflow, bus.fifo_underflow, bus.access_overflow},
                    {m_fovf, m_funf, m_aovf});
            end
        end
        idle();
    endtask

    initial begin
        idle();
        clear_trig();
        test_reset();
        test_execute_equal();
        test_store_group();
        test_priority();
        test_fifo_limits();
        test_back_to_back();
        test_bypass();
        test_saturation();
        test_reset_mid_group();
        test_access_overflow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
